// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator and DAC output stage.
// Counters walk active -> front porch -> sync -> back porch. The stage-0 decode
// (x, y, de, line_start, frame_start) goes to the renderer. Blanking and syncs
// are delayed by the renderer latency so they line up with the returned colour.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 8,
    parameter int PIX_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic [10:0]        x,
    output logic [9:0]         y,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               h_sync,
    output logic               v_sync,
    output logic               blank_n,
    output logic               sync_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Comparisons are done one bit wider than the counters so that a sync
    // end equal to the full line/frame length still fits.
    localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG_C = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END_C = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    // Reject geometries the counters cannot hold and unsupported latencies.
    if (H_TOTAL > 2048) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL %0d exceeds 2048", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
    end
    if ((PIX_LAT < 0) || (PIX_LAT > 4)) begin : g_bad_pix_lat
        $error("vga_timing_gen: PIX_LAT %0d outside 0..4", PIX_LAT);
    end

    logic [10:0] h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic [11:0] h_ext_s;
    logic [10:0] v_ext_s;
    logic        de_s;
    logic        hs_raw_s;
    logic        vs_raw_s;
    logic        de_d_s;
    logic        hs_d_s;
    logic        vs_d_s;

    // Raster counters: h wraps every line, v advances on the h wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= 10'd0;
        end else if (h_cnt_r == H_LAST_C) begin
            h_cnt_r <= 11'd0;
            if (v_cnt_r == V_LAST_C) begin
                v_cnt_r <= 10'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 11'd1;
        end
    end

    assign h_ext_s = {1'b0, h_cnt_r};
    assign v_ext_s = {1'b0, v_cnt_r};

    // Stage-0 decode straight from the counters; vs_raw only moves when v_cnt
    // does, i.e. on the h_cnt==0 clock.
    always_comb begin
        de_s        = (h_ext_s < H_ACT_C) && (v_ext_s < V_ACT_C);
        hs_raw_s    = (h_ext_s >= HS_BEG_C) && (h_ext_s < HS_END_C);
        vs_raw_s    = (v_ext_s >= VS_BEG_C) && (v_ext_s < VS_END_C);
        line_start  = (h_cnt_r == 11'd0);
        frame_start = (h_cnt_r == 11'd0) && (v_cnt_r == 10'd0);
    end

    assign x  = h_cnt_r;
    assign y  = v_cnt_r;
    assign de = de_s;

    if (PIX_LAT > 0) begin : g_delay
        // Each entry holds {de, hs_raw, vs_raw}; cleared entries mean blanked
        // with syncs inactive, so no partial pulse escapes after reset.
        logic [2:0] dly_r [PIX_LAT];

        // Shift the control bits along with the renderer pipeline.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < PIX_LAT; i++) begin
                    dly_r[i] <= 3'b000;
                end
            end else begin
                dly_r[0] <= {de_s, hs_raw_s, vs_raw_s};
                for (int i = 1; i < PIX_LAT; i++) begin
                    dly_r[i] <= dly_r[i-1];
                end
            end
        end

        assign {de_d_s, hs_d_s, vs_d_s} = dly_r[PIX_LAT-1];
    end else begin : g_no_delay
        assign {de_d_s, hs_d_s, vs_d_s} = {de_s, hs_raw_s, vs_raw_s};
    end

    // DAC output registers: colour is forced to zero whenever blanked.
    always_ff @(posedge clk) begin
        if (reset) begin
            red     <= {COLOR_W{1'b0}};
            green   <= {COLOR_W{1'b0}};
            blue    <= {COLOR_W{1'b0}};
            blank_n <= 1'b0;
            h_sync  <= ~HS_POL;
            v_sync  <= ~VS_POL;
        end else begin
            red     <= de_d_s ? pix_r : {COLOR_W{1'b0}};
            green   <= de_d_s ? pix_g : {COLOR_W{1'b0}};
            blue    <= de_d_s ? pix_b : {COLOR_W{1'b0}};
            blank_n <= de_d_s;
            h_sync  <= hs_d_s ? HS_POL : ~HS_POL;
            v_sync  <= vs_d_s ? VS_POL : ~VS_POL;
        end
    end

    // No sync-on-green.
    assign sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// u_a: 640-wide lines with a short 13-line frame (6/2/2/3), PIX_LAT=1, checked
//      against a hand-computed vector table and per-cycle expectations.
// u_b / u_c: same geometry with PIX_LAT=0 and 3 for renderer alignment.
// u_s: tiny 8/2/3/2 x 4/1/1/1 raster with active-high syncs.
module tb_vga_timing_gen;

    logic clk;
    logic reset;
    int   k_r;
    bit   started;
    int   checks;
    int   errors;

    // ---------------- DUT signals ----------------
    logic [10:0] x_a, x_b, x_c, x_s;
    logic [9:0]  y_a, y_b, y_c, y_s;
    logic        de_a, de_b, de_c, de_s;
    logic        ls_a, ls_b, ls_c, ls_s;
    logic        fs_a, fs_b, fs_c, fs_s;
    logic [7:0]  pr_a, pg_a, pr_b, pg_b, pr_c, pg_c;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c, r_s, g_s, b_s;
    logic        hs_a, vs_a, bl_a, sn_a;
    logic        hs_b, vs_b, bl_b, sn_b;
    logic        hs_c, vs_c, bl_c, sn_c;
    logic        hs_s, vs_s, bl_s, sn_s;
    logic [7:0]  ra_x, ra_y;
    logic [7:0]  rc_x [3];
    logic [7:0]  rc_y [3];

    vga_timing_gen #(.V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIX_LAT(1)) u_a (
        .clk(clk), .reset(reset), .x(x_a), .y(y_a), .de(de_a), .line_start(ls_a),
        .frame_start(fs_a), .pix_r(pr_a), .pix_g(pg_a), .pix_b(8'hFF), .red(r_a),
        .green(g_a), .blue(b_a), .h_sync(hs_a), .v_sync(vs_a), .blank_n(bl_a), .sync_n(sn_a));

    vga_timing_gen #(.V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIX_LAT(0)) u_b (
        .clk(clk), .reset(reset), .x(x_b), .y(y_b), .de(de_b), .line_start(ls_b),
        .frame_start(fs_b), .pix_r(pr_b), .pix_g(pg_b), .pix_b(8'hFF), .red(r_b),
        .green(g_b), .blue(b_b), .h_sync(hs_b), .v_sync(vs_b), .blank_n(bl_b), .sync_n(sn_b));

    vga_timing_gen #(.V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIX_LAT(3)) u_c (
        .clk(clk), .reset(reset), .x(x_c), .y(y_c), .de(de_c), .line_start(ls_c),
        .frame_start(fs_c), .pix_r(pr_c), .pix_g(pg_c), .pix_b(8'hFF), .red(r_c),
        .green(g_c), .blue(b_c), .h_sync(hs_c), .v_sync(vs_c), .blank_n(bl_c), .sync_n(sn_c));

    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .HS_POL(1'b1), .VS_POL(1'b1)) u_s (
        .clk(clk), .reset(reset), .x(x_s), .y(y_s), .de(de_s), .line_start(ls_s),
        .frame_start(fs_s), .pix_r(8'h55), .pix_g(8'h66), .pix_b(8'h77), .red(r_s),
        .green(g_s), .blue(b_s), .h_sync(hs_s), .v_sync(vs_s), .blank_n(bl_s), .sync_n(sn_s));

    // ---------------- clock, cycle index, renderer models ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since the last reset edge: 0 is the first clock out of reset.
    always @(posedge clk) k_r <= reset ? 0 : k_r + 1;

    // Renderers: pix_r = x[7:0], pix_g = y[7:0] with latency 0, 1 and 3.
    assign pr_b = x_b[7:0];
    assign pg_b = y_b[7:0];
    always @(posedge clk) begin
        ra_x <= x_a[7:0];
        ra_y <= y_a[7:0];
    end
    assign pr_a = ra_x;
    assign pg_a = ra_y;
    always @(posedge clk) begin
        rc_x[0] <= x_c[7:0];
        rc_y[0] <= y_c[7:0];
        rc_x[1] <= rc_x[0];
        rc_y[1] <= rc_y[0];
        rc_x[2] <= rc_x[1];
        rc_y[2] <= rc_y[1];
    end
    assign pr_c = rc_x[2];
    assign pg_c = rc_y[2];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t k=%0d)", name, act, exp, $time, k_r);
        end
    endtask

    // Expected {blank_n, h_sync, v_sync, red, green, blue} at cycle k for the
    // 800 x 13 raster with total output latency lat+1.
    function automatic logic [26:0] exp_out(input int k, input int lat);
        int s;
        int h;
        int v;
        logic bl;
        s = k - lat - 1;
        if (s < 0) return {1'b0, 1'b1, 1'b1, 24'h000000};
        h  = s % 800;
        v  = (s / 800) % 13;
        bl = (h < 640) && (v < 6);
        return {bl, !((h >= 656) && (h < 752)), !((v >= 8) && (v < 10)),
                bl ? 8'(h) : 8'h00, bl ? 8'(v) : 8'h00, bl ? 8'hFF : 8'h00};
    endfunction

    // ---------------- continuous monitors ----------------
    int ls_age, fs_age, hs_run, vs_run, bl_run;
    bit ls_seen, fs_seen, hs_prev, vs_prev;
    int s_fs_age, s_hs_run, s_vs_run;
    bit s_fs_seen;

    always begin
        @(negedge clk);
        if (reset || !started) begin
            ls_age = 0; fs_age = 0; hs_run = 0; vs_run = 0; bl_run = 0;
            ls_seen = 1'b0; fs_seen = 1'b0; hs_prev = 1'b1; vs_prev = 1'b1;
            s_fs_age = 0; s_hs_run = 0; s_vs_run = 0; s_fs_seen = 1'b0;
        end else begin
            check("sb_lat1", {bl_a, hs_a, vs_a, r_a, g_a, b_a}, exp_out(k_r, 1));
            check("sb_lat0", {bl_b, hs_b, vs_b, r_b, g_b, b_b}, exp_out(k_r, 0));
            check("sb_lat3", {bl_c, hs_c, vs_c, r_c, g_c, b_c}, exp_out(k_r, 3));
            ls_age++;
            fs_age++;
            if (ls_a) begin
                if (ls_seen) check("line_period", ls_age, 800);
                ls_age  = 0;
                ls_seen = 1'b1;
            end
            if (fs_a) begin
                if (fs_seen) check("frame_period", fs_age, 10400);
                fs_age  = 0;
                fs_seen = 1'b1;
            end
            if (ls_seen && hs_prev && !hs_a) check("hs_fall_pos", ls_age, 658);
            if (ls_seen && vs_prev && !vs_a) check("vs_fall_pos", ls_age, 2);
            hs_prev = hs_a;
            vs_prev = vs_a;
            if (!hs_a) hs_run++;
            else if (hs_run != 0) begin check("hs_width", hs_run, 96); hs_run = 0; end
            if (!vs_a) vs_run++;
            else if (vs_run != 0) begin check("vs_width", vs_run, 1600); vs_run = 0; end
            if (bl_a) bl_run++;
            else if (bl_run != 0) begin check("blank_width", bl_run, 640); bl_run = 0; end
            // small raster, active-high syncs
            s_fs_age++;
            if (fs_s) begin
                if (s_fs_seen) check("s_frame_period", s_fs_age, 105);
                s_fs_age  = 0;
                s_fs_seen = 1'b1;
            end
            if (hs_s) s_hs_run++;
            else if (s_hs_run != 0) begin check("s_hs_width", s_hs_run, 3); s_hs_run = 0; end
            if (vs_s) s_vs_run++;
            else if (s_vs_run != 0) begin check("s_vs_width", s_vs_run, 15); s_vs_run = 0; end
        end
    end

    // ---------------- directed vector table for u_a ----------------
    typedef struct {
        int          k;
        logic [10:0] x;
        logic [9:0]  y;
        logic        de, ls, fs, bl, hs, vs;
        logic [7:0]  r, g, b;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    task automatic wait_k(input int target);
        int g;
        g = 0;
        while ((k_r != target) && (g < 20000)) begin
            @(negedge clk);
            g++;
        end
        check("wait_k", k_r, target);
    endtask

    task automatic run_table(input string tag);
        @(negedge clk);
        for (int i = 0; i < NVEC; i++) begin
            wait_k(tbl[i].k);
            check($sformatf("%s_vec%0d_k%0d", tag, i, tbl[i].k),
                  {x_a, y_a, de_a, ls_a, fs_a, bl_a, hs_a, vs_a, r_a, g_a, b_a},
                  {tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].ls, tbl[i].fs,
                   tbl[i].bl, tbl[i].hs, tbl[i].vs, tbl[i].r, tbl[i].g, tbl[i].b});
        end
    endtask

    initial begin
        //          k      x        y      de    ls    fs    bl    hs    vs    red    green  blue
        tbl[0]  = '{0,     11'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[1]  = '{1,     11'd1,   10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[2]  = '{2,     11'd2,   10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   8'd0, 8'hFF};
        tbl[3]  = '{5,     11'd5,   10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3,   8'd0, 8'hFF};
        tbl[4]  = '{300,   11'd300, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd42,  8'd0, 8'hFF};
        tbl[5]  = '{641,   11'd641, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd127, 8'd0, 8'hFF};
        tbl[6]  = '{642,   11'd642, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[7]  = '{657,   11'd657, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[8]  = '{658,   11'd658, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[9]  = '{753,   11'd753, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[10] = '{754,   11'd754, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[11] = '{800,   11'd0,   10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[12] = '{802,   11'd2,   10'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   8'd1, 8'hFF};
        tbl[13] = '{4800,  11'd0,   10'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[14] = '{4802,  11'd2,   10'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[15] = '{6401,  11'd1,   10'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[16] = '{6402,  11'd2,   10'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0, 8'h00};
        tbl[17] = '{8001,  11'd1,  10'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0, 8'h00};
        tbl[18] = '{8002,  11'd2,  10'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[19] = '{10399, 11'd799,10'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[20] = '{10400, 11'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'h00};
        tbl[21] = '{10402, 11'd2,   10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   8'd0, 8'hFF};

        checks  = 0;
        errors  = 0;
        started = 1'b0;
        reset   = 1'b1;

        // Reset held: stage 0 decodes (0,0), output registers stay at reset values.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold%0d_stage0", i), {x_a, y_a, de_a, ls_a, fs_a},
                  {11'd0, 10'd0, 1'b1, 1'b1, 1'b1});
            check($sformatf("hold%0d_out", i), {bl_a, hs_a, vs_a, sn_a, r_a, g_a, b_a},
                  {1'b0, 1'b1, 1'b1, 1'b0, 24'h000000});
            check($sformatf("hold%0d_small", i), {bl_s, hs_s, vs_s, sn_s, r_s},
                  {1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        started = 1'b1;

        run_table("run1");

        // One-clock reset in the middle of a sync pulse of frame 2 (v=4, h=700).
        wait_k(10400 + 4 * 800 + 700 - 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("pre_reset_pos", {x_a, y_a}, {11'd700, 10'd4});
        check("pre_reset_hs", {bl_a, hs_a}, {1'b0, 1'b0});
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_table("run2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the run is about 25k cycles.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
